// File: rtl/nn_stream_pkg.sv
// nn_stream_pkg
//   Shared definitions for the streaming layer pipeline: the serializer
//   state encoding and the meaning of the pause/freeze control levels
//   that both the serializer and the neuron side agree on.
package nn_stream_pkg;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_STREAM = 2'd1,
        SER_DRAIN  = 2'd2,
        SER_FROZEN = 2'd3
    } ser_state_t;

    // pause: downstream accumulators hold while asserted.
    localparam logic PAUSE_HOLD     = 1'b1;
    localparam logic PAUSE_RUN      = 1'b0;
    // freeze: downstream results are final, neurons hold outputs.
    localparam logic FREEZE_HOLD    = 1'b1;
    localparam logic FREEZE_RELEASE = 1'b0;

endpackage

// File: rtl/layer_serializer.sv
// layer_serializer
//   Captures one layer's packed result bus and broadcasts it one element
//   per cycle to the next streaming layer, then waits a drain period and
//   freezes the downstream layer.
//
// Ports
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   in_valid/in_ready  frame handshake; in_ready is decoded from state
//   in_data          packed frame, element i at [DATA_WIDTH*i +: DATA_WIDTH]
//   hold             bubble request, only honored while streaming
//   stream_data      element broadcast to the downstream layer
//   pause            1 = stream_data not valid this cycle
//   freeze           1 = downstream results final
//   frame_done       one-cycle pulse on entry to FROZEN
module layer_serializer
    import nn_stream_pkg::*;
#(
    parameter int NUM_ELEM     = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] in_data,
    input  logic                           hold,
    output logic [DATA_WIDTH-1:0]          stream_data,
    output logic                           pause,
    output logic                           freeze,
    output logic                           frame_done
);

    localparam int IDX_W      = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    ser_state_t                    state_q, state_d;
    logic [NUM_ELEM*DATA_WIDTH-1:0] frame_q;
    logic [IDX_W-1:0]              index_q, index_nxt;
    logic [DRAIN_W-1:0]            drain_q;
    logic [DATA_WIDTH-1:0]         data_q;
    logic                          pause_q, freeze_q, done_q;

    logic accept, step, last_elem, drain_end;
    logic pause_d, freeze_d, done_d;

    assign accept    = in_valid && in_ready;
    assign step      = (state_q == SER_STREAM) && !hold;
    assign last_elem = (index_q == IDX_W'(NUM_ELEM - 1));
    assign drain_end = (drain_q == DRAIN_W'(DRAIN_LAST));
    assign index_nxt = last_elem ? index_q : index_q + 1'b1;

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= SER_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_IDLE, SER_FROZEN: if (accept) state_d = SER_STREAM;
            SER_STREAM: if (step && last_elem)
                state_d = (DRAIN_CYCLES > 0) ? SER_DRAIN : SER_FROZEN;
            SER_DRAIN:  if (drain_end) state_d = SER_FROZEN;
            default:    state_d = SER_IDLE;
        endcase
    end

    // Output decode: in_ready is combinational, the rest are next values
    // for the output registers. hold folds into pause in its own cycle.
    always_comb begin
        in_ready = rst_n && ((state_q == SER_IDLE) || (state_q == SER_FROZEN));
        pause    = pause_q | ((state_q == SER_STREAM) && hold);
        pause_d  = (state_d == SER_STREAM) ? PAUSE_RUN : PAUSE_HOLD;
        freeze_d = (state_d == SER_FROZEN) ? FREEZE_HOLD : FREEZE_RELEASE;
        done_d   = (state_d == SER_FROZEN) && (state_q != SER_FROZEN);
    end

    // Datapath and registered outputs.
    // NOTE: frame_q carries no reset; it is only read after a handshake
    // has loaded it, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (accept) frame_q <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index_q  <= '0;
            drain_q  <= '0;
            data_q   <= '0;
            pause_q  <= PAUSE_HOLD;
            freeze_q <= FREEZE_RELEASE;
            done_q   <= 1'b0;
        end else begin
            pause_q  <= pause_d;
            freeze_q <= freeze_d;
            done_q   <= done_d;
            // Counter restarts on every DRAIN entry.
            drain_q  <= (state_q == SER_DRAIN && state_d == SER_DRAIN)
                        ? drain_q + 1'b1 : '0;
            if (accept) begin
                index_q <= '0;
                data_q  <= in_data[DATA_WIDTH-1:0];
            end else if (step && !last_elem) begin
                index_q <= index_nxt;
                data_q  <= frame_q[DATA_WIDTH*int'(index_nxt) +: DATA_WIDTH];
            end
        end
    end

    assign stream_data = data_q;
    assign freeze      = freeze_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer
//   Directed bench for layer_serializer: default instance (10 elements,
//   drain 3) and a minimal instance (1 element, no drain).
module tb_layer_serializer;

    localparam int NE = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, hold, pause, freeze, frame_done;
    logic [NE*DW-1:0] in_data;
    logic [DW-1:0]    stream_data;

    logic in_valid1, in_ready1, pause1, freeze1, frame_done1;
    logic hold1 = 1'b0;
    logic [DW-1:0] in_data1, stream_data1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    layer_serializer u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .hold(hold), .stream_data(stream_data),
        .pause(pause), .freeze(freeze), .frame_done(frame_done)
    );

    layer_serializer #(.NUM_ELEM(1), .DATA_WIDTH(DW), .DRAIN_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .hold(hold1), .stream_data(stream_data1),
        .pause(pause1), .freeze(freeze1), .frame_done(frame_done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic p, input logic f,
                              input logic fd, input logic r);
        #1;
        check({tag, ".pause"},      32'(pause),      32'(p));
        check({tag, ".freeze"},     32'(freeze),     32'(f));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
        check({tag, ".in_ready"},   32'(in_ready),   32'(r));
    endtask

    task automatic expect_out(input string tag, input logic [DW-1:0] d, input logic p,
                              input logic f, input logic fd, input logic r);
        check({tag, ".data"}, 32'(stream_data), 32'(d));
        expect_ctl(tag, p, f, fd, r);
    endtask

    function automatic logic [NE*DW-1:0] mk_frame(input logic [DW-1:0] base);
        logic [NE*DW-1:0] fr;
        for (int i = 0; i < NE; i++) fr[DW*i +: DW] = base + DW'(i);
        return fr;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0;

        // Reset state.
        cyc(); cyc();
        #1;
        expect_out("rst", 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst.u1_pause",  32'(pause1),  32'd1);
        check("rst.u1_freeze", 32'(freeze1), 32'd0);
        check("rst.u1_data",   32'(stream_data1), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_release.in_ready", 32'(in_ready), 32'd1);

        // Frame 1..10, no holds: elements t+1..t+10, drain t+11..13, freeze t+14.
        cyc();
        in_valid = 1'b1; in_data = mk_frame(16'd1);
        expect_ctl("t1_idle", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= NE; k++) begin
            cyc();
            in_valid = 1'b0;
            expect_out($sformatf("t1_e%0d", k - 1), DW'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            expect_ctl($sformatf("t1_drain%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(); expect_ctl("t1_frozen",  1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); expect_ctl("t1_frozen2", 1'b1, 1'b1, 1'b0, 1'b1);

        // Frame B with a 2-cycle hold at element 4; frame C offered throughout
        // must be ignored until the first FROZEN cycle.
        in_valid = 1'b1; in_data = mk_frame(16'h0B00);
        for (int k = 0; k < 4; k++) begin
            cyc();
            in_data = mk_frame(16'h0C00);
            expect_out($sformatf("t2_e%0d", k), 16'h0B00 + DW'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(); hold = 1'b1; expect_out("t2_hold1", 16'h0B04, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); hold = 1'b1; expect_out("t2_hold2", 16'h0B04, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); hold = 1'b0; expect_out("t2_e4",    16'h0B04, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 5; k < NE; k++) begin
            cyc();
            expect_out($sformatf("t2_e%0d", k), 16'h0B00 + DW'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(); hold = 1'b1;
            expect_ctl($sformatf("t2_drain%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(); hold = 1'b0;
        expect_ctl("t2_frozen", 1'b1, 1'b1, 1'b1, 1'b1);

        // Back-to-back: handshake in first FROZEN cycle, freeze drops with C0.
        cyc(); in_valid = 1'b0;
        expect_out("t3_e0", 16'h0C00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            expect_out($sformatf("t3_e%0d", k), 16'h0C00 + DW'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset while element 6 is on the stream.
        rst_n = 1'b0;
        cyc();
        expect_out("t4_rst", 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 check("t4_release.in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 16; k++) begin
            cyc();
            expect_ctl($sformatf("t4_idle%0d", k), 1'b1, 1'b0, 1'b0, 1'b1);
        end

        // Single element, no drain: element at t+1, freeze/done at t+2.
        in_valid1 = 1'b1; in_data1 = 16'hA5A5;
        #1 check("t5_idle.in_ready", 32'(in_ready1), 32'd1);
        cyc(); in_valid1 = 1'b0;
        #1;
        check("t5_e0.data",       32'(stream_data1), 32'hA5A5);
        check("t5_e0.pause",      32'(pause1),       32'd0);
        check("t5_e0.freeze",     32'(freeze1),      32'd0);
        check("t5_e0.frame_done", 32'(frame_done1),  32'd0);
        check("t5_e0.in_ready",   32'(in_ready1),    32'd0);
        cyc(); #1;
        check("t5_frozen.pause",      32'(pause1),      32'd1);
        check("t5_frozen.freeze",     32'(freeze1),     32'd1);
        check("t5_frozen.frame_done", 32'(frame_done1), 32'd1);
        check("t5_frozen.in_ready",   32'(in_ready1),   32'd1);
        cyc(); #1;
        check("t5_frozen2.frame_done", 32'(frame_done1), 32'd0);
        check("t5_frozen2.freeze",     32'(freeze1),     32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
